// File: rtl/ram_reader_module_pkg.sv
// rtl/ram_reader_module_pkg.sv - shared state encoding and default widths for the RAM reader
package ram_reader_module_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_reader_module_latency_pipe.sv
// rtl/ram_reader_module_latency_pipe.sv - RD_LATENCY-deep shift register carrying read-valid tokens
module latency_pipe_module #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   output logic valid_tap,
   output logic pipe_busy
);

   logic [RD_LATENCY-1:0] pipe_q;
   logic [RD_LATENCY-1:0] pipe_d;

   // shift the token one stage per cycle; stage 0 takes the current read enable
   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = valid_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // token register, cleared immediately on reset so no stale read is reported
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   // the last stage lines up with the RAM returning data for that token
   assign valid_tap = pipe_q[RD_LATENCY-1];
   assign pipe_busy = |pipe_q;

endmodule

// File: rtl/ram_reader_module.sv
// rtl/ram_reader_module.sv - start-triggered sequential RAM reader with latency compensation and checksum
module ram_reader_module
   import ram_reader_module_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_sig,
   output logic              done_sig,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [DATA_W-1:0] checksum,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              valid_q, valid_d;
   logic              tap;
   logic              pipe_busy;

   latency_pipe_module #(
      .RD_LATENCY (RD_LATENCY)
   ) u_latency_pipe (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (rd_en),
      .valid_tap (tap),
      .pipe_busy (pipe_busy)
   );

   // sequencer: issue DEPTH addresses, then wait for every token and the output strobe to drain
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start_sig) begin
               state_d = ST_READ;
               addr_d  = '0;
            end
         end
         ST_READ: begin
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (!pipe_busy && !valid_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // capture returned words when a token reaches the tap; checksum restarts with each run
   always_comb begin
      data_d  = data_q;
      valid_d = tap;
      sum_d   = sum_q;
      if (state_q == ST_IDLE && start_sig) begin
         sum_d = '0;
      end
      if (tap) begin
         data_d = rd_data;
         sum_d  = sum_q + rd_data;
      end
   end

   // state and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
      end
   end

   assign rd_en      = (state_q == ST_READ);
   assign rd_addr    = addr_q;
   assign done_sig   = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign checksum   = sum_q;

endmodule

// File: tb/tb_ram_reader_module.sv
// tb/tb_ram_reader_module.sv - scoreboard bench for ram_reader_module
module tb_ram_reader_module;

   localparam int NU = 3;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   logic       clk;
   logic       rst        [NU];
   logic       start      [NU];
   logic       done_sig   [NU];
   logic       rd_en      [NU];
   logic [3:0] rd_addr    [NU];
   logic [7:0] rd_data    [NU];
   logic [7:0] data_out   [NU];
   logic       data_valid [NU];
   logic [7:0] checksum   [NU];
   logic       busy       [NU];

   logic [7:0] mem   [NU][16];
   logic [7:0] dpipe [NU][4];

   exp_t aq [NU][$];
   exp_t wq [NU][$];
   exp_t dq [NU][$];

   int cyc = 0;
   int chk = 0;
   int err = 0;

   function automatic int lat_of(int u);
      return (u == 1) ? 3 : 1;
   endfunction

   function automatic int dep_of(int u);
      return (u == 2) ? 1 : 16;
   endfunction

   ram_reader_module #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LATENCY(1)) dut0 (
      .clk(clk), .rst(rst[0]), .start_sig(start[0]), .done_sig(done_sig[0]),
      .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
      .data_out(data_out[0]), .data_valid(data_valid[0]), .checksum(checksum[0]), .busy(busy[0]));

   ram_reader_module #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LATENCY(3)) dut1 (
      .clk(clk), .rst(rst[1]), .start_sig(start[1]), .done_sig(done_sig[1]),
      .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
      .data_out(data_out[1]), .data_valid(data_valid[1]), .checksum(checksum[1]), .busy(busy[1]));

   ram_reader_module #(.ADDR_W(4), .DATA_W(8), .DEPTH(1), .RD_LATENCY(1)) dut2 (
      .clk(clk), .rst(rst[2]), .start_sig(start[2]), .done_sig(done_sig[2]),
      .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
      .data_out(data_out[2]), .data_valid(data_valid[2]), .checksum(checksum[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural synchronous RAM: garbage on the read pipe whenever rd_en is low
   always @(posedge clk) begin
      for (int u = 0; u < NU; u++) begin
         for (int j = 3; j > 0; j--) dpipe[u][j] <= dpipe[u][j-1];
         dpipe[u][0] <= rd_en[u] ? mem[u][rd_addr[u]] : 8'($urandom);
      end
   end

   assign rd_data[0] = dpipe[0][0];
   assign rd_data[1] = dpipe[1][2];
   assign rd_data[2] = dpipe[2][0];

   task automatic check(string name, int act, int exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_run(int u, int s, int csum);
      for (int i = 0; i < dep_of(u); i++) begin
         aq[u].push_back('{cyc: s + i, val: i});
         wq[u].push_back('{cyc: s + i + lat_of(u) + 1, val: int'(mem[u][i])});
      end
      dq[u].push_back('{cyc: s + dep_of(u) + lat_of(u) + 2, val: csum});
   endtask

   task automatic wait_until(int n);
      while (cyc < n) @(negedge clk);
   endtask

   // monitor: pop and compare whenever a DUT presents an address, a word or a done pulse
   always @(negedge clk) begin
      exp_t e;
      for (int u = 0; u < NU; u++) begin
         if (rd_en[u] === 1'b1) begin
            if (aq[u].size() == 0) begin
               check($sformatf("u%0d_unexpected_rd_en", u), 1, 0);
            end else begin
               e = aq[u].pop_front();
               check($sformatf("u%0d_rd_addr", u), int'(rd_addr[u]), e.val);
               check($sformatf("u%0d_rd_cycle", u), cyc, e.cyc);
            end
         end
         if (data_valid[u] === 1'b1) begin
            if (wq[u].size() == 0) begin
               check($sformatf("u%0d_unexpected_data_valid", u), 1, 0);
            end else begin
               e = wq[u].pop_front();
               check($sformatf("u%0d_data_out", u), int'(data_out[u]), e.val);
               check($sformatf("u%0d_data_cycle", u), cyc, e.cyc);
            end
         end
         if (done_sig[u] === 1'b1) begin
            if (dq[u].size() == 0) begin
               check($sformatf("u%0d_unexpected_done", u), 1, 0);
            end else begin
               e = dq[u].pop_front();
               check($sformatf("u%0d_done_checksum", u), int'(checksum[u]), e.val);
               check($sformatf("u%0d_done_cycle", u), cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      for (int u = 0; u < NU; u++) begin
         rst[u]   = 1'b1;
         start[u] = 1'b0;
         for (int i = 0; i < 16; i++) mem[u][i] = 8'h00;
      end
      #3;
      for (int u = 0; u < NU; u++) begin
         check($sformatf("u%0d_reset_rd_en", u), int'(rd_en[u]), 0);
         check($sformatf("u%0d_reset_rd_addr", u), int'(rd_addr[u]), 0);
         check($sformatf("u%0d_reset_data_out", u), int'(data_out[u]), 0);
         check($sformatf("u%0d_reset_data_valid", u), int'(data_valid[u]), 0);
         check($sformatf("u%0d_reset_checksum", u), int'(checksum[u]), 0);
         check($sformatf("u%0d_reset_done", u), int'(done_sig[u]), 0);
         check($sformatf("u%0d_reset_busy", u), int'(busy[u]), 0);
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < NU; u++) rst[u] = 1'b0;
      @(negedge clk);

      // incrementing words at latency 1, index words at latency 3, single-word run
      for (int i = 0; i < 16; i++) begin
         mem[0][i] = 8'(i + 1);
         mem[1][i] = 8'(i);
      end
      mem[2][0] = 8'h5A;
      for (int u = 0; u < NU; u++) start[u] = 1'b1;
      s = cyc + 1;
      expect_run(0, s, 8'h88);
      expect_run(1, s, 8'h78);
      expect_run(2, s, 8'h5A);
      @(negedge clk);
      for (int u = 0; u < NU; u++) start[u] = 1'b0;
      wait_until(s + 26);
      check("t1_busy_after_run", int'(busy[0]), 0);
      check("t1_checksum_held", int'(checksum[0]), 8'h88);
      check("t3_checksum_held", int'(checksum[1]), 8'h78);

      // constant 0xF0 words: checksum wraps to zero
      for (int i = 0; i < 16; i++) mem[0][i] = 8'hF0;
      start[0] = 1'b1;
      s = cyc + 1;
      expect_run(0, s, 8'h00);
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 23);

      // start pulses while busy are ignored
      for (int i = 0; i < 16; i++) mem[0][i] = 8'(i + 1);
      start[0] = 1'b1;
      s = cyc + 1;
      expect_run(0, s, 8'h88);
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 5);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 18);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 30);
      check("t4_no_restart_busy", int'(busy[0]), 0);

      // reset in the middle of a run, then a clean run
      start[0] = 1'b1;
      s = cyc + 1;
      expect_run(0, s, 8'h88);
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 8);
      check("t5_checksum_before_rst", int'(checksum[0]), 28);
      #2;
      rst[0] = 1'b1;
      #1;
      check("t5_rst_rd_en", int'(rd_en[0]), 0);
      check("t5_rst_data_valid", int'(data_valid[0]), 0);
      check("t5_rst_checksum", int'(checksum[0]), 0);
      check("t5_rst_done", int'(done_sig[0]), 0);
      check("t5_rst_busy", int'(busy[0]), 0);
      aq[0].delete();
      wq[0].delete();
      dq[0].delete();
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) mem[0][i] = 8'(8'h10 + i);
      start[0] = 1'b1;
      s = cyc + 1;
      expect_run(0, s, 8'h78);
      @(negedge clk);
      start[0] = 1'b0;
      wait_until(s + 23);

      // start held high: back-to-back runs every 21 cycles
      for (int i = 0; i < 16; i++) mem[0][i] = 8'(i + 1);
      start[0] = 1'b1;
      s = cyc + 1;
      for (int k = 0; k < 3; k++) expect_run(0, s + 21 * k, 8'h88);
      wait_until(s + 20);
      check("t6_idle_gap_busy", int'(busy[0]), 0);
      check("t6_checksum_held", int'(checksum[0]), 8'h88);
      @(negedge clk);
      check("t6_checksum_cleared", int'(checksum[0]), 0);
      check("t6_restart_busy", int'(busy[0]), 1);
      wait_until(s + 42);
      start[0] = 1'b0;
      wait_until(s + 42 + 25);
      check("t6_final_busy", int'(busy[0]), 0);

      for (int u = 0; u < NU; u++) begin
         check($sformatf("u%0d_addr_queue_left", u), aq[u].size(), 0);
         check($sformatf("u%0d_word_queue_left", u), wq[u].size(), 0);
         check($sformatf("u%0d_done_queue_left", u), dq[u].size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
